// File: rtl/sat_addsub_arbiter.sv
// Round-robin arbiter that shares one 16-bit signed saturating add/sub unit
// between NREQ requesters and holds each result in a one-entry tagged response slot.
module sat_addsub_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_ovfl,
    output logic [IDW-1:0]       rsp_id
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  rr_ptr_nxt_s;
    logic            can_accept_s;
    logic            grant_s;
    logic [NREQ-1:0] mask_hi_s;
    logic [NREQ-1:0] hi_s;
    logic [NREQ-1:0] cand_s;
    logic [IDW-1:0]  gnt_id_s;
    logic [NREQ-1:0] gnt_vec_s;
    logic [15:0]     a_s;
    logic [15:0]     b_s;
    logic            sub_s;
    logic [16:0]     res_s;
    logic [15:0]     sum_r;
    logic            ovfl_r;
    logic [IDW-1:0]  id_r;

    // Exact 17-bit A+B or A+~B+1; a sign mismatch between bits 16 and 15 means
    // the result left the 16-bit range, and bit 16 tells which rail to clamp to.
    function automatic logic [16:0] sat_addsub(input logic [15:0] a,
                                               input logic [15:0] b,
                                               input logic        sub);
        logic [15:0] b_op;
        logic [16:0] r;
        logic [16:0] res;
        b_op = sub ? ~b : b;
        r    = {a[15], a} + {b_op[15], b_op} + {16'h0000, sub};
        if (r[16] != r[15]) begin
            res = {1'b1, (r[16] ? 16'h8000 : 16'h7FFF)};
        end else begin
            res = {1'b0, r[15:0]};
        end
        return res;
    endfunction

    // Slot can take a new result when empty or when its current one drains this cycle.
    always_comb begin
        can_accept_s = (state_r == EMPTY) || (rsp_valid && rsp_ready);
    end

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
    always_comb begin
        mask_hi_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            mask_hi_s[i] = (i >= int'(rr_ptr_r));
        end
        hi_s     = req_valid & mask_hi_s;
        cand_s   = (|hi_s) ? hi_s : req_valid;
        gnt_id_s = {IDW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            gnt_id_s = cand_s[i] ? IDW'(i) : gnt_id_s;
        end
    end

    // Grant is suppressed during reset and whenever the slot cannot take a result.
    always_comb begin
        grant_s   = rst_n && can_accept_s && (|req_valid);
        gnt_vec_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            gnt_vec_s[i] = grant_s && (gnt_id_s == IDW'(i));
        end
        req_ready = gnt_vec_s;
    end

    // Steer the winner's operands into the shared adder.
    always_comb begin
        a_s   = 16'h0000;
        b_s   = 16'h0000;
        sub_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_s   = (gnt_id_s == IDW'(i)) ? req_a[16*i +: 16] : a_s;
            b_s   = (gnt_id_s == IDW'(i)) ? req_b[16*i +: 16] : b_s;
            sub_s = (gnt_id_s == IDW'(i)) ? req_sub[i]        : sub_s;
        end
        res_s = sat_addsub(a_s, b_s, sub_s);
    end

    // Pointer moves just past the winner so it becomes lowest priority next round.
    always_comb begin
        if (gnt_id_s == IDW'(NREQ - 1)) begin
            rr_ptr_nxt_s = {IDW{1'b0}};
        end else begin
            rr_ptr_nxt_s = gnt_id_s + IDW'(1'b1);
        end
    end

    // Slot next-state: a grant always (re)fills; a drain without grant empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (grant_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (grant_s) begin
                    state_nxt_s = FULL;
                end else if (rsp_ready) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Response payload and arbitration pointer update only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r    <= 16'h0000;
            ovfl_r   <= 1'b0;
            id_r     <= {IDW{1'b0}};
            rr_ptr_r <= {IDW{1'b0}};
        end else if (grant_s) begin
            sum_r    <= res_s[15:0];
            ovfl_r   <= res_s[16];
            id_r     <= gnt_id_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    assign rsp_valid = (state_r == FULL);
    assign rsp_sum   = sum_r;
    assign rsp_ovfl  = ovfl_r;
    assign rsp_id    = id_r;

endmodule

// File: doc/sat_addsub_arbiter.md
Name: sat_addsub_arbiter

Overview:
- Shares one 16-bit signed saturating add/sub datapath between NREQ requesters, e.g. ALU, address-offset and PC-branch paths, so only one adder instance is needed.
- Provides round-robin arbitration and a valid/ready handshake on every request port.
- Holds each result in a registered one-entry response slot, tagged with the winning requester's ID.
- Sits between the decode/issue logic and the writeback mux.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 1, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  16*NREQ  operand A, signed; requester i uses bits [16i+15:16i].
- req_b  in  16*NREQ  operand B, signed; same packing as req_a.
- req_sub  in  NREQ  1 = A-B, 0 = A+B.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer accepts the response.
- rsp_sum  out  16  saturated result.
- rsp_ovfl  out  1  1 when the unsaturated result overflowed.
- rsp_id  out  IDW  index of the requester that produced the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_sum=16'h0000, rsp_ovfl=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0; state=EMPTY.
  - req_ready is all-zero while rst_n is low.
- Arithmetic, 17-bit signed exact, computed combinationally on the granted operands:
  - Exact result R = A+B, or A-B when req_sub=1. A-B is A + ~B + 1.
  - R > 32767 -> sum=16'h7FFF, ovfl=1.
  - R < -32768 -> sum=16'h8000, ovfl=1.
  - Otherwise sum=R[15:0], ovfl=0.
  - Examples: 16'h8000 - 16'h0001 saturates to 16'h8000; 16'h0000 - 16'h8000 saturates to 16'h7FFF.
- Slot states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1; rsp_sum, rsp_ovfl and rsp_id are stable until the response is accepted.
- can_accept = (state==EMPTY) || (rsp_valid && rsp_ready).
- Arbitration, combinational in the same cycle:
  - Search requesters rr_ptr, rr_ptr+1, ... modulo NREQ.
  - The first one with req_valid=1 wins, provided can_accept is true.
  - req_ready[winner]=1; every other bit is 0.
  - If no request is valid, or can_accept=0, req_ready=0.
  - req_ready may depend on req_valid. A requester must hold valid and its operands stable until it sees ready.
- Grant cycle (req_valid[i] && req_ready[i]):
  - On the next edge the slot loads sum, ovfl and id=i.
  - State becomes FULL; rr_ptr becomes (i+1) mod NREQ.
  - Latency is 1 cycle from accept to rsp_valid.
- Drain without a new grant (rsp_valid && rsp_ready, no grant): next state EMPTY, rsp_valid=0.
- Simultaneous drain and grant in the same cycle:
  - The slot reloads with the new result; rsp_valid stays 1 with no bubble.
  - Sustained throughput is 1 operation per cycle.
- Backpressure: while FULL and rsp_ready=0, all req_ready=0 and rr_ptr holds.
- rr_ptr advances only on a grant. Idle cycles do not rotate it.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants go 0,1,..,NREQ-1,0,...
- No request is ever dropped or duplicated. Exactly one response is produced per accepted request, in acceptance order.
- Reset asserted mid-operation discards a pending response. A request accepted in the edge coincident with reset is lost; requesters re-issue after reset.
- req_valid bits at or above NREQ do not exist. Operands of unselected requesters are don't-care.

Test Plan:
1. Reset then single request: req0 valid with A=16'h0005, B=16'h0003, sub=0 -> req_ready=2'b01 that cycle; next cycle rsp_valid=1, rsp_sum=16'h0008, ovfl=0, id=0.
2. Saturation: A=16'h7FFF, B=16'h0001, add -> 16'h7FFF, ovfl=1. A=16'h8000, B=16'h0001, sub -> 16'h8000, ovfl=1. A=16'hFFFF, B=16'hFFFF, add -> 16'hFFFE, ovfl=0.
3. Round-robin: both requesters continuously valid, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id follows the same sequence one cycle later with no bubbles.
4. Backpressure: slot FULL with id=1, rsp_ready=0 for 3 cycles while req0 is valid -> req_ready=0 and outputs stable; rsp_ready=1 -> req0 granted the same cycle and the next result appears with no empty cycle.
5. Async reset mid-stream: assert rst_n=0 between clock edges while FULL -> rsp_valid drops immediately; after release, the first grant goes to req0.
6. Random constrained run with NREQ=3: 10k requests against a scoreboard -> every response matches the saturating reference, order is preserved, and no requester waits more than NREQ grants.
